// File: rtl/mm2s_packet_router.sv
// mm2s_packet_router
// Takes the single MCDMA MM2S stream, locks the destination channel from
// tdest on the first beat of each packet, and writes every beat of that
// packet into the matching per-channel FIFO through a registered write port.
// Packets aimed at a channel that does not exist are swallowed whole and
// counted in a saturating 16-bit drop counter.
module mm2s_packet_router #(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int FIFO_DATA_WIDTH = 32,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int AXIS_DEST_WIDTH = 4,
    parameter int NUM_CHANNELS    = 2
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,

    output logic                                  SRC_AXIS_tready_out,
    input  logic [AXIS_DATA_WIDTH-1:0]            SRC_AXIS_tdata_in,
    input  logic [AXIS_DEST_WIDTH-1:0]            SRC_AXIS_tdest_in,
    input  logic [AXIS_KEEP_WIDTH-1:0]            SRC_AXIS_tkeep_in,
    input  logic                                  SRC_AXIS_tlast_in,
    input  logic                                  SRC_AXIS_tuser_in,
    input  logic                                  SRC_AXIS_tvalid_in,

    output logic [FIFO_DATA_WIDTH*NUM_CHANNELS-1:0] fifo_data_out,
    output logic [NUM_CHANNELS-1:0]               fifo_last_out,
    output logic [NUM_CHANNELS-1:0]               fifo_w_stb_out,
    input  logic [NUM_CHANNELS-1:0]               fifo_not_full_in,

    output logic [15:0]                           drop_count_out,
    output logic [1:0]                            dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DROP  = 2'd2
    } state_t;

    // Channel count widened by one bit so 2^AXIS_DEST_WIDTH channels still fits.
    localparam logic [AXIS_DEST_WIDTH:0] NUM_CH_EXT = (AXIS_DEST_WIDTH + 1)'(NUM_CHANNELS);

    state_t                       state_q;
    logic [AXIS_DEST_WIDTH-1:0]   dest_q;
    logic [FIFO_DATA_WIDTH-1:0]   data_q;
    logic                         last_q;
    logic [NUM_CHANNELS-1:0]      stb_q;
    logic [15:0]                  drop_count_q;
    logic [15:0]                  drop_count_d;

    logic [NUM_CHANNELS-1:0]      dest_onehot;
    logic                         dest_in_range;
    logic                         tready;
    logic                         beat_accept;

    // tkeep and tuser carry nothing this block acts on; beats are written whole.
    logic                         unused_inputs;
    assign unused_inputs = ^{SRC_AXIS_tkeep_in, SRC_AXIS_tuser_in};

    // A tdest below NUM_CHANNELS names a real FIFO; anything else is dropped.
    assign dest_in_range = {1'b0, SRC_AXIS_tdest_in} < NUM_CH_EXT;

    // Decode the locked destination into a one-hot channel select.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        dest_onehot = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (dest_q == AXIS_DEST_WIDTH'(i)) begin
                dest_onehot[i] = 1'b1;
            end
        end
    end

    // Stream ready: follows only the locked FIFO's space flag in ROUTE, always
    // open in DROP, closed in IDLE while the next packet's tdest is sampled.
    always_comb begin
        tready = 1'b0;
        unique case (state_q)
            ROUTE:   tready = |(fifo_not_full_in & dest_onehot);
            DROP:    tready = 1'b1;
            default: tready = 1'b0;
        endcase
    end

    assign beat_accept = SRC_AXIS_tvalid_in & tready;

    // Saturating drop counter next value: bumps on the tlast of a dropped packet.
    always_comb begin
        drop_count_d = drop_count_q;
        if ((state_q == DROP) && beat_accept && SRC_AXIS_tlast_in &&
            (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    // Packet FSM with registered FIFO write port and drop counter.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            dest_q       <= '0;
            data_q       <= '0;
            last_q       <= 1'b0;
            stb_q        <= '0;
            drop_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments in clocked logic, so every
            // register samples the pre-edge values regardless of order.
            stb_q        <= '0;
            drop_count_q <= drop_count_d;
            unique case (state_q)
                IDLE: begin
                    if (SRC_AXIS_tvalid_in) begin
                        dest_q  <= SRC_AXIS_tdest_in;
                        state_q <= dest_in_range ? ROUTE : DROP;
                    end
                end
                ROUTE: begin
                    // dest_q stays locked here, so mid-packet tdest changes are ignored.
                    if (beat_accept) begin
                        data_q <= SRC_AXIS_tdata_in;
                        last_q <= SRC_AXIS_tlast_in;
                        stb_q  <= dest_onehot;
                        if (SRC_AXIS_tlast_in) begin
                            state_q <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (beat_accept && SRC_AXIS_tlast_in) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign SRC_AXIS_tready_out = tready;
    assign fifo_data_out       = {NUM_CHANNELS{data_q}};
    assign fifo_w_stb_out      = stb_q;
    assign fifo_last_out       = {NUM_CHANNELS{last_q}} & stb_q;
    assign drop_count_out      = drop_count_q;
    assign dbg_state           = state_q;

endmodule

// File: tb/tb_mm2s_packet_router.sv
// Self-checking bench for mm2s_packet_router (NUM_CHANNELS=2, 32-bit data).
// A scoreboard queue holds the FIFO writes the bench expects; a negedge
// monitor pops and compares on every strobe. Scenario tasks add cycle-exact
// inline comparisons.
module tb_mm2s_packet_router;

    localparam int NCH = 2;

    logic        clk;
    logic        rst_in;
    logic        tready;
    logic [31:0] tdata;
    logic [3:0]  tdest;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tuser;
    logic        tvalid;
    logic [63:0] fifo_data;
    logic [1:0]  fifo_last;
    logic [1:0]  fifo_stb;
    logic [1:0]  fifo_nf;
    logic [15:0] drop_count;
    logic [1:0]  dbg_state;

    typedef struct {
        int          ch;
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    // Bench-side packet model
    logic        in_pkt   = 1'b0;
    logic [3:0]  pkt_dest = 4'd0;
    logic [15:0] exp_drop = 16'd0;

    mm2s_packet_router #(
        .AXIS_DATA_WIDTH (32),
        .FIFO_DATA_WIDTH (32),
        .AXIS_KEEP_WIDTH (4),
        .AXIS_DEST_WIDTH (4),
        .NUM_CHANNELS    (NCH)
    ) dut (
        .clk_in              (clk),
        .rst_in              (rst_in),
        .SRC_AXIS_tready_out (tready),
        .SRC_AXIS_tdata_in   (tdata),
        .SRC_AXIS_tdest_in   (tdest),
        .SRC_AXIS_tkeep_in   (tkeep),
        .SRC_AXIS_tlast_in   (tlast),
        .SRC_AXIS_tuser_in   (tuser),
        .SRC_AXIS_tvalid_in  (tvalid),
        .fifo_data_out       (fifo_data),
        .fifo_last_out       (fifo_last),
        .fifo_w_stb_out      (fifo_stb),
        .fifo_not_full_in    (fifo_nf),
        .drop_count_out      (drop_count),
        .dbg_state           (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    // Scoreboard monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [1:0] es;
        if (fifo_stb != 2'b00) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_unexpected_write: got stb=%b data=%h want no write", fifo_stb, fifo_data);
            end else begin
                e  = sb_q.pop_front();
                es = (e.ch == 0) ? 2'b01 : 2'b10;
                if (fifo_stb !== es || fifo_data !== {2{e.data}} || fifo_last !== (e.last ? es : 2'b00))
                    $display("FAIL sb_write: got stb=%b data=%h last=%b want stb=%b data=%h last=%b",
                             fifo_stb, fifo_data[31:0], fifo_last, es, e.data, e.last ? es : 2'b00);
                else
                    n_pass++;
            end
        end
    end

    // Present one beat (called in the first half of a cycle) and hold it until
    // accepted; records the expected write or drop in the bench model.
    task automatic send_beat(input logic [3:0] dest, input logic [31:0] data, input logic last);
        bit done = 1'b0;
        if (!in_pkt) begin
            pkt_dest = dest;
            in_pkt   = 1'b1;
        end
        tvalid = 1'b1;
        tdest  = dest;
        tdata  = data;
        tlast  = last;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (tready) begin
                if (int'(pkt_dest) < NCH)
                    sb_q.push_back('{int'(pkt_dest), data, last});
                else if (last && exp_drop != 16'hFFFF)
                    exp_drop = exp_drop + 16'd1;
                if (last) in_pkt = 1'b0;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL send_beat_timeout: beat %h got no tready within 64 cycles, want accept", data);
        end
    endtask

    task automatic test_reset;
        rst_in = 1'b1;
        tvalid = 1'b1;
        tdest  = 4'd1;
        tdata  = 32'h55;
        tlast  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++; if (tready !== 1'b0) $display("FAIL reset_tready[%0d]: got %b want 0", k, tready); else n_pass++;
            n_checks++; if (fifo_stb !== 2'b00) $display("FAIL reset_stb[%0d]: got %b want 00", k, fifo_stb); else n_pass++;
            n_checks++; if (drop_count !== 16'd0) $display("FAIL reset_drop[%0d]: got %h want 0", k, drop_count); else n_pass++;
            n_checks++; if (dbg_state !== 2'd0) $display("FAIL reset_state[%0d]: got %0d want 0", k, dbg_state); else n_pass++;
            n_checks++; if (fifo_data !== 64'd0 || fifo_last !== 2'b00)
                $display("FAIL reset_data[%0d]: got data=%h last=%b want 0", k, fifo_data, fifo_last); else n_pass++;
        end
        rst_in = 1'b0;
        @(negedge clk);
        n_checks++; if (dbg_state !== 2'd1) $display("FAIL reset_release_state: got %0d want 1", dbg_state); else n_pass++;
        n_checks++; if (tready !== 1'b1) $display("FAIL reset_release_tready: got %b want 1", tready); else n_pass++;
        sb_q.push_back('{1, 32'h55, 1'b1});
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
        @(negedge clk);
        n_checks++; if (dbg_state !== 2'd0) $display("FAIL reset_pkt_done_state: got %0d want 0", dbg_state); else n_pass++;
    endtask

    task automatic test_routing;
        logic [31:0] d;
        @(posedge clk);
        #1;
        tvalid = 1'b1;
        tdest  = 4'd1;
        tdata  = 32'hA0;
        tlast  = 1'b0;
        @(negedge clk);
        n_checks++; if (dbg_state !== 2'd0) $display("FAIL route_idle_state: got %0d want 0", dbg_state); else n_pass++;
        n_checks++; if (tready !== 1'b0) $display("FAIL route_idle_tready: got %b want 0", tready); else n_pass++;
        @(posedge clk);
        #1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            d = 32'hA0 + 32'(i);
            n_checks++; if (tready !== 1'b1) $display("FAIL route_tready[%0d]: got %b want 1", i, tready); else n_pass++;
            sb_q.push_back('{1, d, (i == 3)});
            @(posedge clk);
            #1;
            if (i < 3) begin
                tdata = d + 32'd1;
                tlast = (i == 2);
            end else begin
                tvalid = 1'b0;
                tlast  = 1'b0;
            end
            @(negedge clk);
            n_checks++; if (fifo_stb !== 2'b10) $display("FAIL route_stb[%0d]: got %b want 10", i, fifo_stb); else n_pass++;
            n_checks++; if (fifo_data !== {2{d}}) $display("FAIL route_data[%0d]: got %h want %h", i, fifo_data[63:32], d); else n_pass++;
            n_checks++; if (fifo_last !== ((i == 3) ? 2'b10 : 2'b00))
                $display("FAIL route_last[%0d]: got %b want %b", i, fifo_last, (i == 3) ? 2'b10 : 2'b00); else n_pass++;
        end
        @(negedge clk);
        n_checks++; if (fifo_stb !== 2'b00) $display("FAIL route_end_stb: got %b want 00", fifo_stb); else n_pass++;
        n_checks++; if (dbg_state !== 2'd0) $display("FAIL route_end_state: got %0d want 0", dbg_state); else n_pass++;
    endtask

    task automatic test_backpressure;
        @(posedge clk);
        #1;
        send_beat(4'd0, 32'hB0, 1'b0);
        // Channel 0 goes full; channel 1 stays free to show it has no effect.
        fifo_nf = 2'b10;
        tdata   = 32'hB1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++; if (tready !== 1'b0) $display("FAIL bp_tready[%0d]: got %b want 0", k, tready); else n_pass++;
            n_checks++; if (fifo_stb !== ((k == 0) ? 2'b01 : 2'b00))
                $display("FAIL bp_stb[%0d]: got %b want %b", k, fifo_stb, (k == 0) ? 2'b01 : 2'b00); else n_pass++;
        end
        @(posedge clk);
        #1;
        // Channel 0 has room again; channel 1 full must not stall the stream.
        fifo_nf = 2'b01;
        send_beat(4'd0, 32'hB1, 1'b0);
        send_beat(4'd0, 32'hB2, 1'b1);
        tvalid = 1'b0;
        tlast  = 1'b0;
        fifo_nf = 2'b11;
        repeat (2) @(negedge clk);
        n_checks++; if (sb_q.size() != 0) $display("FAIL bp_all_written: got %0d pending want 0", sb_q.size()); else n_pass++;
    endtask

    task automatic test_drop;
        @(posedge clk);
        #1;
        send_beat(4'd5, 32'hD0, 1'b0);
        #1;
        n_checks++; if (tready !== 1'b1) $display("FAIL drop_tready: got %b want 1", tready); else n_pass++;
        n_checks++; if (dbg_state !== 2'd2) $display("FAIL drop_state: got %0d want 2", dbg_state); else n_pass++;
        n_checks++; if (drop_count !== exp_drop) $display("FAIL drop_count_mid: got %h want %h", drop_count, exp_drop); else n_pass++;
        send_beat(4'd5, 32'hD1, 1'b1);
        tvalid = 1'b0;
        tlast  = 1'b0;
        #1;
        n_checks++; if (drop_count !== exp_drop || exp_drop !== 16'd1)
            $display("FAIL drop_count_inc: got %h want %h", drop_count, 16'd1); else n_pass++;
        n_checks++; if (dbg_state !== 2'd0) $display("FAIL drop_done_state: got %0d want 0", dbg_state); else n_pass++;

        // Normal routing resumes after a drop.
        @(posedge clk);
        #1;
        send_beat(4'd0, 32'hC0, 1'b0);
        send_beat(4'd0, 32'hC1, 1'b1);
        tvalid = 1'b0;
        tlast  = 1'b0;

        // Saturation: preload near the top, then drop two more packets.
        @(posedge clk);
        #1;
        force dut.drop_count_q = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.drop_count_q;
        exp_drop = 16'hFFFE;
        #1;
        n_checks++; if (drop_count !== exp_drop) $display("FAIL drop_preset: got %h want %h", drop_count, exp_drop); else n_pass++;
        for (int k = 0; k < 2; k++) begin
            send_beat(4'hF, 32'hE0 + 32'(k), 1'b1);
            tvalid = 1'b0;
            tlast  = 1'b0;
            #1;
            n_checks++; if (drop_count !== 16'hFFFF) $display("FAIL drop_sat[%0d]: got %h want ffff", k, drop_count); else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        @(posedge clk);
        #1;
        send_beat(4'd0, 32'h70, 1'b0);
        // tdest toggles on beat 2 but the packet stays locked to channel 0.
        send_beat(4'd1, 32'h71, 1'b1);
        tvalid = 1'b1;
        tdest  = 4'd1;
        tdata  = 32'h72;
        tlast  = 1'b1;
        #1;
        n_checks++; if (dbg_state !== 2'd0 || tready !== 1'b0)
            $display("FAIL b2b_bubble: got state=%0d tready=%b want 0/0", dbg_state, tready); else n_pass++;
        n_checks++; if (fifo_stb !== 2'b01 || fifo_last !== 2'b01)
            $display("FAIL b2b_first_last: got stb=%b last=%b want 01/01", fifo_stb, fifo_last); else n_pass++;
        send_beat(4'd1, 32'h72, 1'b1);
        tvalid = 1'b0;
        tlast  = 1'b0;
        #1;
        n_checks++; if (fifo_stb !== 2'b10 || fifo_data[63:32] !== 32'h72)
            $display("FAIL b2b_second: got stb=%b data=%h want 10/72", fifo_stb, fifo_data[63:32]); else n_pass++;
    endtask

    task automatic test_reset_mid_packet;
        @(posedge clk);
        #1;
        send_beat(4'd1, 32'h90, 1'b0);
        send_beat(4'd1, 32'h91, 1'b0);
        // Beat 3 carries a new tdest; it is presented while reset hits.
        tvalid = 1'b1;
        tdest  = 4'd0;
        tdata  = 32'h92;
        tlast  = 1'b0;
        rst_in = 1'b1;
        @(posedge clk);
        #1;
        rst_in   = 1'b0;
        in_pkt   = 1'b0;
        exp_drop = 16'd0;
        #1;
        n_checks++; if (tready !== 1'b0 || fifo_stb !== 2'b00 || dbg_state !== 2'd0)
            $display("FAIL rstmid_ctrl: got tready=%b stb=%b state=%0d want 0/00/0", tready, fifo_stb, dbg_state); else n_pass++;
        n_checks++; if (fifo_data !== 64'd0 || fifo_last !== 2'b00 || drop_count !== exp_drop)
            $display("FAIL rstmid_regs: got data=%h last=%b drop=%h want 0/00/%h", fifo_data, fifo_last, drop_count, exp_drop); else n_pass++;
        send_beat(4'd0, 32'h92, 1'b0);
        send_beat(4'd0, 32'h93, 1'b0);
        send_beat(4'd0, 32'h94, 1'b1);
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    initial begin
        rst_in  = 1'b1;
        tvalid  = 1'b0;
        tdata   = 32'd0;
        tdest   = 4'd0;
        tkeep   = 4'hF;
        tlast   = 1'b0;
        tuser   = 1'b0;
        fifo_nf = 2'b11;

        test_reset();
        test_routing();
        test_backpressure();
        test_drop();
        test_back_to_back();
        test_reset_mid_packet();

        repeat (3) @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) $display("FAIL sb_drained: got %0d pending writes want 0", sb_q.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
